mul_seq_ctrl: RTL and testbench

- Sequencer for the execute-stage iterative multiplier.
- Drives one shared 64-bit ripple adder datapath (sum = a + b, carry-out discarded) as a radix-2 shift-add engine.
- Covers RV32M MUL/MULH/MULHSU/MULHU: one op in flight, valid/ready handshake on both sides, flush support for mispredict recovery.

---
 rtl/mul_seq_ctrl_if.sv | 34 +++
 rtl/mul_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mul_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_ctrl_if
// Description : Issue/result handshake bundle for the iterative multiplier.
//               The master offers ops and consumes results; the slave is the
//               multiplier sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_seq_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface
`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_ctrl
// Description : Radix-2 shift-add sequencer for RV32M MUL/MULH/MULHSU/MULHU.
//               Operands are reduced to magnitudes on accept, multiplied over
//               XLEN cycles on one shared 2*XLEN adder, then sign-fixed by
//               negating through the same adder. One op in flight, flushable.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  mul_seq_ctrl_if.slave bus,
  output logic          busy
);

  localparam int P_W   = 2 * XLEN;
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [P_W-1:0]   acc_q;
  logic [P_W-1:0]   mcand_q;
  logic [XLEN-1:0]  mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_q;
  logic [1:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [XLEN-1:0]  out_data_q;
  logic [TAG_W-1:0] out_tag_q;

  // Operand sign handling and magnitude extraction for the accept cycle.
  logic            rs1_neg_d, rs2_neg_d;
  logic [XLEN-1:0] rs1_mag_d, rs2_mag_d;

  // Shared adder: accumulates in CALC, forms ~acc + 1 in FIX.
  logic [P_W-1:0] add_a, add_b, add_sum, acc_final_d;

  // Decode signedness and form operand magnitudes (0x80000000 maps to itself,
  // which is the correct unsigned magnitude 2^31).
  always_comb begin
    rs1_neg_d = ((bus.in_op == OP_MULH) || (bus.in_op == OP_MULHSU)) && bus.in_rs1[XLEN-1];
    rs2_neg_d = (bus.in_op == OP_MULH) && bus.in_rs2[XLEN-1];
    rs1_mag_d = rs1_neg_d ? ((~bus.in_rs1) + XLEN'(1)) : bus.in_rs1;
    rs2_mag_d = rs2_neg_d ? ((~bus.in_rs2) + XLEN'(1)) : bus.in_rs2;
  end

  // Steer the single adder's operands according to the current phase.
  always_comb begin
    add_a = acc_q;
    add_b = mcand_q;
    if (state_q == S_FIX) begin
      add_a = ~acc_q;
      add_b = P_W'(1);
    end
    add_sum     = add_a + add_b;
    acc_final_d = neg_q ? add_sum : acc_q;
  end

  // Sequencer FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      op_q        <= 2'b00;
      tag_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else if (flush) begin
      // Flush beats both accept and result handoff; the result is dropped.
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q       <= bus.in_op;
            tag_q      <= bus.in_tag;
            mcand_q    <= {{XLEN{1'b0}}, rs1_mag_d};
            mplier_q   <= rs2_mag_d;
            neg_q      <= rs1_neg_d ^ rs2_neg_d;
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= S_CALC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_CALC: begin
          if (mplier_q[0]) acc_q <= add_sum;
          mcand_q  <= {mcand_q[P_W-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[XLEN-1:1]};
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= S_FIX;
        end
        S_FIX: begin
          acc_q       <= acc_final_d;
          out_data_q  <= (op_q == OP_MUL) ? acc_final_d[XLEN-1:0] : acc_final_d[P_W-1:XLEN];
          out_tag_q   <= tag_q;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;
  assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_seq_ctrl
// Description : Directed self-checking bench for mul_seq_ctrl with
//               hand-computed products, latency, backpressure, flush and
//               asynchronous reset scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_ctrl;

  localparam int XLEN  = 32;
  localparam int TAG_W = 6;

  logic clk;
  logic rst;
  logic flush;
  logic busy;

  int checks = 0;
  int errors = 0;
  int lat;

  mul_seq_ctrl_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  mul_seq_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus),
    .busy (busy)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a handshake never completes.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: present an op, confirm it is acceptable, let it go in.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rs1   = a;
    bus.in_rs2   = b;
    bus.in_tag   = tag;
    chk("in_ready_before_accept", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Counts negedges after the accept edge until out_valid rises (bounded).
  task automatic wait_result(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 100);
  endtask

  // Called at a negedge with out_valid=1: take the result, confirm drain.
  task automatic drain();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_after_drain", {63'd0, bus.out_valid}, 64'd0);
    chk("in_ready_after_drain", {63'd0, bus.in_ready}, 64'd1);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] tag, input logic [31:0] exp);
    int n;
    issue(op, a, b, tag);
    wait_result(n);
    chk({name, "_latency"}, 64'(n), 64'd34);
    chk({name, "_data"}, {32'd0, bus.out_data}, {32'd0, exp});
    chk({name, "_tag"}, {58'd0, bus.out_tag}, {58'd0, tag});
    drain();
  endtask

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_out_data", {32'd0, bus.out_data}, 64'd0);
    chk("reset_out_tag", {58'd0, bus.out_tag}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic products across all four opcodes and sign corners.
    run_op("mul_7x6",         2'b00, 32'd7,        32'd6,        6'd5,  32'h0000002A);
    run_op("mulh_m1xm1",      2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd11, 32'h00000000);
    run_op("mulhu_ffxff",     2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd12, 32'hFFFFFFFE);
    run_op("mul_ffxff",       2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd13, 32'h00000001);
    run_op("mulhsu_minxff",   2'b10, 32'h80000000, 32'hFFFFFFFF, 6'd14, 32'h80000000);
    run_op("mulh_minxmin",    2'b01, 32'h80000000, 32'h80000000, 6'd15, 32'h40000000);
    run_op("mulhsu_m1x2",     2'b10, 32'hFFFFFFFF, 32'd2,        6'd16, 32'hFFFFFFFF);
    run_op("mul_m3x5",        2'b00, 32'hFFFFFFFD, 32'd5,        6'd17, 32'hFFFFFFF1);

    // Backpressure: hold the result for 10 cycles while a new op is offered.
    issue(2'b11, 32'h00010000, 32'h00010000, 6'd42);
    wait_result(lat);
    chk("bp_latency", 64'(lat), 64'd34);
    bus.in_valid = 1'b1;
    bus.in_op    = 2'b00;
    bus.in_rs1   = 32'd9;
    bus.in_rs2   = 32'd9;
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("bp_out_data", {32'd0, bus.out_data}, 64'd1);
      chk("bp_out_tag", {58'd0, bus.out_tag}, 64'd42);
      chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    drain();
    chk("bp_busy_after_drain", {63'd0, busy}, 64'd0);

    // Flush mid-CALC: the op must vanish, then the next op goes in at once.
    issue(2'b00, 32'd9, 32'd9, 6'd3);
    repeat (15) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
    run_op("mul_3x5_after_flush", 2'b00, 32'd3, 32'd5, 6'd7, 32'h0000000F);

    // Asynchronous reset in the middle of CALC.
    issue(2'b01, 32'h12345678, 32'h9ABCDEF0, 6'd33);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("arst_out_data", {32'd0, bus.out_data}, 64'd0);
    chk("arst_out_tag", {58'd0, bus.out_tag}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    run_op("mul_after_rst", 2'b00, 32'd7, 32'd6, 6'd63, 32'h0000002A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
